giro_position_counter: RTL and testbench

Downstream consumer of the rotary-encoder direction outputs (x1 = clockwise detent, x2 = counter-clockwise detent).
- Turns each direction strobe into a bounded position value, with saturate or wrap-around limits.
- Applies speed-dependent step acceleration and reports detent rate per measurement window.
- Feeds menu/setpoint logic with a clean, single-clock-domain position.

---
 rtl/giro_position_counter_if.sv | 26 ++
 rtl/giro_position_counter.sv | 137 +++++++++++++
 tb/tb_giro_position_counter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/giro_position_counter_if.sv
// rtl/giro_position_counter_if.sv - encoder/control inputs and position outputs of the position counter
interface giro_position_counter_if #(
  parameter int WIDTH = 8
);
  logic             cw;
  logic             ccw;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] pos;
  logic             changed;
  logic             dir;
  logic             at_min;
  logic             at_max;
  logic [7:0]       speed;

  modport master (
    output cw, ccw, clr, load, load_val,
    input  pos, changed, dir, at_min, at_max, speed
  );

  modport slave (
    input  cw, ccw, clr, load, load_val,
    output pos, changed, dir, at_min, at_max, speed
  );
endinterface

// File: rtl/giro_position_counter.sv
// rtl/giro_position_counter.sv - bounded rotary-encoder position counter with speed-dependent stepping
module giro_position_counter #(
  parameter int WIDTH       = 8,
  parameter int MIN_POS     = 0,
  parameter int MAX_POS     = 100,
  parameter int WRAP        = 0,
  parameter int WINDOW      = 1000,
  parameter int FAST_THRESH = 4,
  parameter int FAST_STEP   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  giro_position_counter_if.slave bus
);

  localparam int W1  = WIDTH + 1;
  localparam int WCW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  localparam logic [W1-1:0]    MIN_X    = W1'(MIN_POS);
  localparam logic [W1-1:0]    MAX_X    = W1'(MAX_POS);
  localparam logic [W1-1:0]    ONE_X    = W1'(1);
  localparam logic [W1-1:0]    FAST_X   = W1'(FAST_STEP);
  localparam logic [WIDTH-1:0] MIN_P    = WIDTH'(MIN_POS);
  localparam logic [WIDTH-1:0] MAX_P    = WIDTH'(MAX_POS);
  localparam logic [8:0]       THRESH_X = 9'(FAST_THRESH);
  localparam logic [WCW-1:0]   WIN_LAST = WCW'(WINDOW - 1);
  localparam logic [1:0]       ARM_DONE = 2'd3;

  logic             cw_s1_q, cw_s2_q, cw_prev_q;
  logic             ccw_s1_q, ccw_s2_q, ccw_prev_q;
  logic [1:0]       arm_q, arm_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic             changed_q, changed_d;
  logic             dir_q, dir_d;
  logic [7:0]       speed_q, speed_d;
  logic [7:0]       ev_cnt_q, ev_cnt_d, ev_cnt_inc;
  logic [WCW-1:0]   win_q, win_d;

  logic             armed, cw_ev, ccw_ev, accept;
  logic [W1-1:0]    pos_x, step_x, sum_x, up_x, dn_x, load_x;

  // Edge flops run during the arm period so a level held across reset release never looks like a rise.
  assign armed  = (arm_q == ARM_DONE);
  assign cw_ev  = armed & cw_s2_q & ~cw_prev_q;
  assign ccw_ev = armed & ccw_s2_q & ~ccw_prev_q;
  assign accept = (cw_ev ^ ccw_ev) & ~bus.clr & ~bus.load;

  always_comb begin
    pos_x  = {1'b0, pos_q};
    step_x = ({1'b0, speed_q} >= THRESH_X) ? FAST_X : ONE_X;
    sum_x  = pos_x + step_x;

    up_x = sum_x;
    if (sum_x > MAX_X) begin
      up_x = (WRAP != 0) ? (MIN_X + (sum_x - MAX_X - ONE_X)) : MAX_X;
    end

    // Compare before subtracting so the unsigned difference never goes negative.
    dn_x = pos_x - step_x;
    if (pos_x < (MIN_X + step_x)) begin
      dn_x = (WRAP != 0) ? (MAX_X + ONE_X - (MIN_X + step_x - pos_x)) : MIN_X;
    end

    load_x = {1'b0, bus.load_val};
    if (load_x < MIN_X) begin
      load_x = MIN_X;
    end else if (load_x > MAX_X) begin
      load_x = MAX_X;
    end

    pos_d = pos_q;
    if (bus.clr) begin
      pos_d = MIN_P;
    end else if (bus.load) begin
      pos_d = WIDTH'(load_x);
    end else if (accept) begin
      pos_d = cw_ev ? WIDTH'(up_x) : WIDTH'(dn_x);
    end
  end

  always_comb begin
    changed_d  = (pos_d != pos_q);
    dir_d      = accept ? cw_ev : dir_q;
    arm_d      = armed ? arm_q : (arm_q + 2'd1);
    ev_cnt_inc = (accept && (ev_cnt_q != 8'hFF)) ? (ev_cnt_q + 8'd1) : ev_cnt_q;
    // An event landing on the rollover cycle still belongs to the window being closed.
    if (win_q == WIN_LAST) begin
      win_d    = '0;
      speed_d  = ev_cnt_inc;
      ev_cnt_d = '0;
    end else begin
      win_d    = win_q + WCW'(1);
      speed_d  = speed_q;
      ev_cnt_d = ev_cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cw_s1_q    <= 1'b0;
      cw_s2_q    <= 1'b0;
      cw_prev_q  <= 1'b0;
      ccw_s1_q   <= 1'b0;
      ccw_s2_q   <= 1'b0;
      ccw_prev_q <= 1'b0;
      arm_q      <= 2'd0;
      pos_q      <= MIN_P;
      changed_q  <= 1'b0;
      dir_q      <= 1'b0;
      speed_q    <= 8'd0;
      ev_cnt_q   <= 8'd0;
      win_q      <= '0;
    end else begin
      cw_s1_q    <= bus.cw;
      cw_s2_q    <= cw_s1_q;
      cw_prev_q  <= cw_s2_q;
      ccw_s1_q   <= bus.ccw;
      ccw_s2_q   <= ccw_s1_q;
      ccw_prev_q <= ccw_s2_q;
      arm_q      <= arm_d;
      pos_q      <= pos_d;
      changed_q  <= changed_d;
      dir_q      <= dir_d;
      speed_q    <= speed_d;
      ev_cnt_q   <= ev_cnt_d;
      win_q      <= win_d;
    end
  end

  assign bus.pos     = pos_q;
  assign bus.changed = changed_q;
  assign bus.dir     = dir_q;
  assign bus.speed   = speed_q;
  assign bus.at_min  = (pos_q == MIN_P);
  assign bus.at_max  = (pos_q == MAX_P);

endmodule

// File: tb/tb_giro_position_counter.sv
// tb/tb_giro_position_counter.sv - scoreboard bench driving saturate and wrap instances with shared stimulus
module tb_giro_position_counter;
  localparam int WIDTH = 8;
  localparam int MINP  = 0;
  localparam int MAXP  = 100;
  localparam int WIN   = 1000;
  localparam int THR   = 4;
  localparam int FSTEP = 4;
  localparam int RANGE = MAXP - MINP + 1;

  typedef struct {
    int n;
    int pos;
    bit dir;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  giro_position_counter_if #(.WIDTH(WIDTH)) ifc0 ();
  giro_position_counter_if #(.WIDTH(WIDTH)) ifc1 ();

  assign ifc1.cw       = ifc0.cw;
  assign ifc1.ccw      = ifc0.ccw;
  assign ifc1.clr      = ifc0.clr;
  assign ifc1.load     = ifc0.load;
  assign ifc1.load_val = ifc0.load_val;

  giro_position_counter #(.WIDTH(WIDTH), .MIN_POS(MINP), .MAX_POS(MAXP), .WRAP(0),
    .WINDOW(WIN), .FAST_THRESH(THR), .FAST_STEP(FSTEP)) dut0 (.clk(clk), .rst(rst), .bus(ifc0.slave));
  giro_position_counter #(.WIDTH(WIDTH), .MIN_POS(MINP), .MAX_POS(MAXP), .WRAP(1),
    .WINDOW(WIN), .FAST_THRESH(THR), .FAST_STEP(FSTEP)) dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));

  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  int   mpos[2];
  bit   mdir;
  int   win_cnt[int];
  exp_t expq0[$];
  exp_t expq1[$];

  // Edges since reset release; edge 1 is the first edge with rst low.
  always @(posedge clk) edge_n <= rst ? 0 : edge_n + 1;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, exp, edge_n);
    end
  endfunction

  function automatic int dut_pos(input int m);   return (m == 0) ? int'(ifc0.pos) : int'(ifc1.pos); endfunction
  function automatic int dut_dir(input int m);   return (m == 0) ? int'(ifc0.dir) : int'(ifc1.dir); endfunction
  function automatic int dut_atmin(input int m); return (m == 0) ? int'(ifc0.at_min) : int'(ifc1.at_min); endfunction
  function automatic int dut_atmax(input int m); return (m == 0) ? int'(ifc0.at_max) : int'(ifc1.at_max); endfunction
  function automatic int sat8(input int v);      return (v > 255) ? 255 : v; endfunction
  function automatic int cnt_of(input int w);    return win_cnt.exists(w) ? win_cnt[w] : 0; endfunction
  function automatic int clampi(input int v);    return (v < MINP) ? MINP : ((v > MAXP) ? MAXP : v); endfunction

  // Wrap mode is modular arithmetic over the legal range; saturate mode is a plain clamp.
  function automatic int mnext(input int p, input bit up, input int step, input int wrap);
    int off;
    off = p - MINP;
    if (wrap != 0) return MINP + (up ? ((off + step) % RANGE) : ((off - step + RANGE) % RANGE));
    return up ? clampi(p + step) : clampi(p - step);
  endfunction

  function automatic void push(input int m, input int n, input int p);
    exp_t e;
    e.n = n; e.pos = p; e.dir = mdir;
    if (m == 0) expq0.push_back(e); else expq1.push_back(e);
  endfunction

  // Applies whatever the DUT samples at edge n; called at the falling edge just before it.
  function automatic void model_apply(input int n, input bit c, input bit cc,
                                      input bit do_clr, input bit do_load, input int lv);
    int w, step, np;
    if (do_clr || do_load) begin
      np = do_clr ? MINP : clampi(lv);
      for (int m = 0; m < 2; m++) begin
        if (np != mpos[m]) push(m, n, np);
        mpos[m] = np;
      end
      return;
    end
    if (c == cc || n < 4) return;
    w = (n - 1) / WIN;
    win_cnt[w] = cnt_of(w) + 1;
    step = (w > 0 && sat8(cnt_of(w - 1)) >= THR) ? FSTEP : 1;
    mdir = c;
    for (int m = 0; m < 2; m++) begin
      np = mnext(mpos[m], c, step, m);
      if (np != mpos[m]) push(m, n, np);
      mpos[m] = np;
    end
  endfunction

  function automatic void model_reset();
    mpos[0] = MINP; mpos[1] = MINP; mdir = 1'b0;
    win_cnt.delete(); expq0.delete(); expq1.delete();
  endfunction

  task automatic mon_pop(input int m);
    exp_t e;
    if ((m == 0 && expq0.size() == 0) || (m == 1 && expq1.size() == 0)) begin
      checks++; errors++;
      $display("FAIL unexpected_changed dut%0d actual pos=%0d required no pulse (edge %0d)", m, dut_pos(m), edge_n);
      return;
    end
    if (m == 0) e = expq0.pop_front(); else e = expq1.pop_front();
    chk($sformatf("chg_edge_dut%0d", m), edge_n, e.n);
    chk($sformatf("chg_pos_dut%0d", m), dut_pos(m), e.pos);
    chk($sformatf("chg_dir_dut%0d", m), dut_dir(m), int'(e.dir));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ifc0.changed) mon_pop(0);
      if (ifc1.changed) mon_pop(1);
      if (edge_n > 0 && edge_n % WIN == 0) begin
        chk("speed_dut0", int'(ifc0.speed), sat8(cnt_of(edge_n / WIN - 1)));
        chk("speed_dut1", int'(ifc1.speed), sat8(cnt_of(edge_n / WIN - 1)));
      end
    end
  end

  task automatic check_state(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s_pos_dut%0d", tag, m), dut_pos(m), mpos[m]);
      chk($sformatf("%s_dir_dut%0d", tag, m), dut_dir(m), int'(mdir));
      chk($sformatf("%s_atmin_dut%0d", tag, m), dut_atmin(m), int'(mpos[m] == MINP));
      chk($sformatf("%s_atmax_dut%0d", tag, m), dut_atmax(m), int'(mpos[m] == MAXP));
    end
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic pulse(input bit c, input bit cc, input int hold);
    int n;
    n = edge_n + 3;
    ifc0.cw = c; ifc0.ccw = cc;
    idle(2);
    model_apply(n, c, cc, 1'b0, 1'b0, 0);
    idle(hold);
    ifc0.cw = 1'b0; ifc0.ccw = 1'b0;
    idle(2);
  endtask

  task automatic ctl(input bit do_clr, input bit do_load, input int lv);
    ifc0.clr = do_clr; ifc0.load = do_load; ifc0.load_val = WIDTH'(lv);
    model_apply(edge_n + 1, 1'b0, 1'b0, do_clr, do_load, lv);
    idle(1);
    ifc0.clr = 1'b0; ifc0.load = 1'b0;
  endtask

  task automatic wait_offset(input int off);
    while (edge_n % WIN != off) @(negedge clk);
  endtask

  initial begin
    int n, r;
    ifc0.cw = 1'b0; ifc0.ccw = 1'b0; ifc0.clr = 1'b0; ifc0.load = 1'b0; ifc0.load_val = '0;
    model_reset();
    idle(3);
    chk("rst_pos", int'(ifc0.pos), MINP);
    chk("rst_changed", int'(ifc0.changed), 0);
    chk("rst_dir", int'(ifc1.dir), 0);
    chk("rst_speed", int'(ifc0.speed), 0);
    chk("rst_at_min", int'(ifc1.at_min), 1);
    rst = 1'b0;
    idle(5);

    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0, 2);
      chk("slow_cw_pos", int'(ifc0.pos), i + 1);
      idle(2000);
    end
    check_state("slow_cw");

    ctl(1'b0, 1'b1, 99);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0, 2);
      idle(1100);
    end
    chk("sat_max_pos", int'(ifc0.pos), 100);
    chk("sat_at_max", int'(ifc0.at_max), 1);
    ctl(1'b1, 1'b0, 0);
    pulse(1'b0, 1'b1, 2);
    chk("sat_min_pos", int'(ifc0.pos), 0);
    check_state("sat_min");
    ctl(1'b0, 1'b1, 200);
    chk("load_clamp", int'(ifc1.pos), 100);

    ctl(1'b1, 1'b0, 0);
    wait_offset(20);
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 1);
    chk("accel_pre_pos", int'(ifc0.pos), 5);
    wait_offset(5);
    chk("accel_speed", int'(ifc0.speed), 5);
    pulse(1'b1, 1'b0, 1);
    chk("accel_fast_pos", int'(ifc0.pos), 9);
    idle(2100);
    chk("accel_idle_speed", int'(ifc0.speed), 0);
    pulse(1'b1, 1'b0, 1);
    chk("accel_slow_pos", int'(ifc0.pos), 10);

    ctl(1'b0, 1'b1, 100);
    pulse(1'b1, 1'b0, 1);
    chk("wrap_up_pos", int'(ifc1.pos), 0);
    ctl(1'b0, 1'b1, 0);
    pulse(1'b0, 1'b1, 1);
    chk("wrap_dn_pos", int'(ifc1.pos), 100);
    wait_offset(20);
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 1);
    wait_offset(5);
    ctl(1'b0, 1'b1, 98);
    pulse(1'b1, 1'b0, 1);
    chk("wrap_fast_pos", int'(ifc1.pos), 1);
    chk("sat_fast_pos", int'(ifc0.pos), 100);
    check_state("fast_edge");

    pulse(1'b1, 1'b1, 2);
    check_state("both_dirs");
    ctl(1'b0, 1'b1, 50);
    ifc0.cw = 1'b1;
    n = edge_n + 3;
    idle(2);
    ifc0.clr = 1'b1;
    model_apply(n, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    idle(1);
    ifc0.clr = 1'b0; ifc0.cw = 1'b0;
    idle(3);
    chk("clr_beats_cw", int'(ifc0.pos), MINP);
    check_state("clr_cw");

    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)       pulse(1'b1, 1'b0, int'($urandom_range(1, 3)));
      else if (r < 7)  pulse(1'b0, 1'b1, int'($urandom_range(1, 3)));
      else if (r == 7) pulse(1'b1, 1'b1, 1);
      else if (r == 8) ctl(1'b0, 1'b1, int'($urandom_range(0, 255)));
      else             ctl(1'b1, 1'b0, 0);
      idle(int'($urandom_range(0, 250)));
      if (i % 10 == 9) check_state("rand");
    end

    idle(5);
    chk("pending_before_rst", expq0.size() + expq1.size(), 0);
    rst = 1'b1;
    ifc0.cw = 1'b1;
    idle(3);
    rst = 1'b0;
    model_reset();
    idle(10);
    check_state("rst_held_cw");
    ifc0.cw = 1'b0;
    idle(3);
    pulse(1'b1, 1'b0, 2);
    chk("rst_then_cw_pos0", int'(ifc0.pos), 1);
    chk("rst_then_cw_pos1", int'(ifc1.pos), 1);

    idle(20);
    chk("leftover_dut0", expq0.size(), 0);
    chk("leftover_dut1", expq1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
